game_clock_ctrl: RTL and testbench

//  Parametrised game clock/score engine: one-second prescaler, mm:ss clock (count-up or countdown),

---
 rtl/game_clock_ctrl.sv | 153 +++++++++++++++
 tb/tb_game_clock_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_clock_ctrl.sv
// Game clock / score engine: 1 s prescaler, mm:ss up/down clock,
// saturating elapsed timer, decaying score and run/pause/stop control.
module game_clock_ctrl #(
   parameter int TICKS_PER_SEC  = 50_000_000,
   parameter int MIN_W          = 5,
   parameter int MAX_MINUTES    = 30,
   parameter int TIMER_W        = 11,
   parameter int SCORE_W        = 7,
   parameter int SCORE_MAX      = 100,
   parameter int SCORE_MIN      = 10,
   parameter int SCORE_INTERVAL = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic               stop,
   input  logic               countdown,
   input  logic [MIN_W-1:0]   preset_min,
   input  logic [5:0]         preset_sec,
   output logic [MIN_W-1:0]   minutes,
   output logic [5:0]         seconds,
   output logic [TIMER_W-1:0] timer,
   output logic [SCORE_W-1:0] score,
   output logic               running,
   output logic               sec_tick,
   output logic               timeout
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int IW = $clog2(SCORE_INTERVAL + 1);
   localparam logic [PW-1:0]    P_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [IW-1:0]    I_LAST = IW'(SCORE_INTERVAL - 1);
   localparam logic [MIN_W-1:0] M_END  = MIN_W'(MAX_MINUTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    presc;
   logic [IW-1:0]    intv;
   logic             mode_down;
   logic             tick;
   logic             at_end;
   logic [MIN_W-1:0] min_nxt;
   logic [5:0]       sec_nxt;

   // A second is counted only when running and no command overrides it
   assign tick = (state == S_RUN) && !start && !stop && (presc == P_LAST);

   // Clock value after the next second, and whether it is terminal
   always_comb begin
      min_nxt = minutes;
      sec_nxt = seconds;
      at_end  = 1'b0;
      if (mode_down) begin
         if (seconds != 6'd0) begin
            sec_nxt = seconds - 6'd1;
         end else if (minutes != '0) begin
            sec_nxt = 6'd59;
            min_nxt = minutes - 1'b1;
         end
         at_end = (min_nxt == '0) && (sec_nxt == 6'd0);
      end else begin
         if (seconds == 6'd59) begin
            sec_nxt = 6'd0;
            min_nxt = minutes + 1'b1;
         end else begin
            sec_nxt = seconds + 6'd1;
         end
         at_end = (min_nxt == M_END) && (sec_nxt == 6'd0);
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state: start > stop > expiry > pause
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_RUN;
      end else if (stop && (state == S_RUN || state == S_PAUSE)) begin
         state_nxt = S_DONE;
      end else if (tick && at_end) begin
         state_nxt = S_DONE;
      end else if (pause && state == S_RUN) begin
         state_nxt = S_PAUSE;
      end else if (pause && state == S_PAUSE) begin
         state_nxt = S_RUN;
      end
   end

   // State-decoded output
   always_comb begin
      running = (state == S_RUN);
   end

   // Prescaler, clock, timer, score and flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc     <= '0;
         intv      <= '0;
         mode_down <= 1'b0;
         minutes   <= '0;
         seconds   <= 6'd0;
         timer     <= '0;
         score     <= SCORE_W'(SCORE_MAX);
         sec_tick  <= 1'b0;
         timeout   <= 1'b0;
      end else if (start) begin
         presc     <= '0;
         intv      <= '0;
         mode_down <= countdown;
         timer     <= '0;
         score     <= SCORE_W'(SCORE_MAX);
         sec_tick  <= 1'b0;
         timeout   <= 1'b0;
         if (countdown) begin
            minutes <= preset_min;
            seconds <= (preset_sec > 6'd59) ? 6'd59 : preset_sec;
         end else begin
            minutes <= '0;
            seconds <= 6'd0;
         end
      end else begin
         sec_tick <= tick;
         if (state == S_RUN && !stop) begin
            presc <= (presc == P_LAST) ? '0 : presc + 1'b1;
         end
         if (tick) begin
            minutes <= min_nxt;
            seconds <= sec_nxt;
            if (timer != '1) timer <= timer + 1'b1;
            if (intv == I_LAST) begin
               intv <= '0;
               if (score > SCORE_W'(SCORE_MIN)) score <= score - 1'b1;
            end else begin
               intv <= intv + 1'b1;
            end
            if (at_end) timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Bench for game_clock_ctrl: directed scenarios plus random commands,
// compared every cycle against an elapsed-seconds reference model.
module tb_game_clock_ctrl;

   localparam int TPS  = 4;
   localparam int MW   = 5;
   localparam int MAXM = 2;
   localparam int TW   = 5;
   localparam int SW   = 7;
   localparam int SMAX = 5;
   localparam int SMIN = 3;
   localparam int SINT = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          stop = 1'b0;
   logic          countdown = 1'b0;
   logic [MW-1:0] preset_min = '0;
   logic [5:0]    preset_sec = 6'd0;
   logic [MW-1:0] minutes;
   logic [5:0]    seconds;
   logic [TW-1:0] timer;
   logic [SW-1:0] score;
   logic          running;
   logic          sec_tick;
   logic          timeout;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state: game live/paused, phase within second,
   // running seconds elapsed since start, countdown preset in seconds
   bit m_live, m_paused, m_down, m_tick, m_to;
   int m_phase, m_elapsed, m_preset;

   game_clock_ctrl #(
      .TICKS_PER_SEC(TPS), .MIN_W(MW), .MAX_MINUTES(MAXM),
      .TIMER_W(TW), .SCORE_W(SW), .SCORE_MAX(SMAX),
      .SCORE_MIN(SMIN), .SCORE_INTERVAL(SINT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause),
      .stop(stop), .countdown(countdown), .preset_min(preset_min),
      .preset_sec(preset_sec), .minutes(minutes), .seconds(seconds),
      .timer(timer), .score(score), .running(running),
      .sec_tick(sec_tick), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_live = 0; m_paused = 0; m_down = 0; m_tick = 0; m_to = 0;
      m_phase = 0; m_elapsed = 0; m_preset = 0;
   endtask

   function automatic int clock_total();
      int t;
      if (m_down) begin
         t = m_preset - m_elapsed;
         if (t < 0) t = 0;
      end else begin
         t = m_elapsed;
      end
      return t;
   endfunction

   task automatic model_edge();
      m_tick = 0;
      if (reset) begin
         model_reset();
      end else if (start) begin
         m_live = 1; m_paused = 0; m_down = countdown;
         m_phase = 0; m_elapsed = 0; m_to = 0;
         m_preset = int'(preset_min) * 60
                  + ((preset_sec > 6'd59) ? 59 : int'(preset_sec));
      end else if (m_live && stop) begin
         m_live = 0;
      end else if (m_live && m_paused) begin
         if (pause) m_paused = 0;
      end else if (m_live) begin
         if (m_phase == TPS - 1) begin
            m_phase = 0;
            m_elapsed++;
            m_tick = 1;
            if (m_down ? (m_elapsed >= m_preset)
                       : (m_elapsed == MAXM * 60)) begin
               m_live = 0;
               m_to = 1;
            end
         end else begin
            m_phase++;
         end
         if (pause && m_live) m_paused = 1;
      end
   endtask

   task automatic check_all();
      int t, tm, sc;
      t  = clock_total();
      tm = (m_elapsed > (1 << TW) - 1) ? (1 << TW) - 1 : m_elapsed;
      sc = SMAX - m_elapsed / SINT;
      if (sc < SMIN) sc = SMIN;
      chk("minutes",  int'(minutes),  t / 60);
      chk("seconds",  int'(seconds),  t % 60);
      chk("timer",    int'(timer),    tm);
      chk("score",    int'(score),    sc);
      chk("running",  int'(running),  int'(m_live && !m_paused));
      chk("sec_tick", int'(sec_tick), int'(m_tick));
      chk("timeout",  int'(timeout),  int'(m_to));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      start = 0; pause = 0; stop = 0;
   endtask

   initial begin
      int n;
      model_reset();
      repeat (2) cycle();
      reset = 0;
      chk("rst_score", int'(score), SMAX);

      // 1: count-up, 16 cycles -> four seconds
      countdown = 0; start = 1; cycle();
      n = 0;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         if (sec_tick) n++;
         chk("t1_tick_pos", int'(sec_tick), int'(i % 4 == 0));
      end
      chk("t1_ticks", n, 4);
      chk("t1_sec", int'(seconds), 4);
      chk("t1_timer", int'(timer), 4);
      chk("t1_score", int'(score), 4);

      // 2: run to 01:59, then terminal 02:00 and freeze
      repeat (460) cycle();
      chk("t2_min", int'(minutes), 1);
      chk("t2_sec", int'(seconds), 59);
      repeat (4) cycle();
      chk("t2_end_min", int'(minutes), 2);
      chk("t2_end_sec", int'(seconds), 0);
      chk("t2_timeout", int'(timeout), 1);
      chk("t2_running", int'(running), 0);
      chk("t2_timer_sat", int'(timer), 31);
      repeat (20) cycle();
      chk("t2_frozen_min", int'(minutes), 2);
      chk("t2_frozen_to", int'(timeout), 1);

      // 3: countdown from 00:02, then clamp of preset_sec
      countdown = 1; preset_min = '0; preset_sec = 6'd2; start = 1; cycle();
      repeat (4) cycle();
      chk("t3_sec1", int'(seconds), 1);
      chk("t3_to0", int'(timeout), 0);
      repeat (4) cycle();
      chk("t3_sec0", int'(seconds), 0);
      chk("t3_to1", int'(timeout), 1);
      preset_sec = 6'd63; start = 1; cycle();
      chk("t3_clamp", int'(seconds), 59);
      chk("t3_clamp_min", int'(minutes), 0);

      // 4: pause holds the prescaler
      countdown = 0; start = 1; cycle();
      cycle();
      pause = 1; cycle();
      chk("t4_paused", int'(running), 0);
      n = 0;
      repeat (10) begin
         cycle();
         if (sec_tick) n++;
      end
      chk("t4_no_tick", n, 0);
      pause = 1; cycle();
      chk("t4_resumed", int'(running), 1);
      cycle();
      chk("t4_tick_early", int'(sec_tick), 0);
      cycle();
      chk("t4_tick", int'(sec_tick), 1);

      // 5: score decay with floor, restart mid-run
      start = 1; cycle();
      repeat (12) cycle();
      chk("t5_score3s", int'(score), 4);
      repeat (12) cycle();
      chk("t5_score6s", int'(score), 3);
      repeat (12) cycle();
      chk("t5_score9s", int'(score), 3);
      repeat (12) cycle();
      chk("t5_score12s", int'(score), 3);
      chk("t5_timer", int'(timer), 12);
      start = 1; cycle();
      chk("t5_rs_sec", int'(seconds), 0);
      chk("t5_rs_score", int'(score), 5);
      chk("t5_rs_timer", int'(timer), 0);

      // 6: command priority, stop on final tick, async reset
      repeat (5) cycle();
      start = 1; stop = 1; pause = 1; cycle();
      chk("t6_restart", int'(running), 1);
      chk("t6_restart_tmr", int'(timer), 0);
      countdown = 1; preset_min = '0; preset_sec = 6'd1; start = 1; cycle();
      repeat (3) cycle();
      stop = 1; cycle();
      chk("t6_stop_to", int'(timeout), 0);
      chk("t6_stop_run", int'(running), 0);
      chk("t6_stop_sec", int'(seconds), 1);
      chk("t6_stop_tick", int'(sec_tick), 0);
      countdown = 0; start = 1; cycle();
      repeat (9) cycle();
      #2 reset = 1;
      #1 model_reset();
      check_all();
      chk("t6_rst_score", int'(score), SMAX);
      chk("t6_rst_sec", int'(seconds), 0);
      #1 reset = 0;

      // Random command stream
      for (int i = 0; i < 3000; i++) begin
         start      = ($urandom_range(0, 99) < 2);
         stop       = ($urandom_range(0, 199) < 1);
         pause      = ($urandom_range(0, 99) < 4);
         countdown  = $urandom_range(0, 1);
         preset_min = MW'($urandom_range(0, 3));
         preset_sec = 6'($urandom_range(0, 63));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
